// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake: one-cycle logic, arithmetic and shift ops,
// plus iterative shift-add unsigned multiply and restoring unsigned divide.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [3:0]       ALUOperation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Zero,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_NOR  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_MULU = 4'b0111;
  localparam logic [3:0] OP_DIVU = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic                 zero_q, zero_d;
  logic                 dbz_q, dbz_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic                 div_ok;
  logic [WIDTH-1:0]     div_rem_next;
  logic [WIDTH-1:0]     div_q_next;
  logic [WIDTH-1:0]     single_res;

  function automatic logic [WIDTH-1:0] alu_single(input logic [3:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOR:  r = ~(a | b);
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLL:  r = b << a[SHW-1:0];
      OP_SRL:  r = b >> a[SHW-1:0];
      default: r = '0;
    endcase
    return r;
  endfunction

  // One multiply / divide iteration; acc holds {partial product, multiplier} or the dividend/quotient.
  always_comb begin
    mul_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next     = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift    = {rem_q, acc_q[WIDTH-1]};
    div_diff     = div_shift - {1'b0, opnd_q};
    div_ok       = ~div_diff[WIDTH];
    div_rem_next = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_q_next   = {acc_q[WIDTH-2:0], div_ok};
    single_res   = alu_single(ALUOperation, A, B);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    res_d    = res_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    dbz_d    = dbz_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          dbz_d = 1'b0;
          if (ALUOperation == OP_MULU) begin
            opnd_d   = A;
            acc_d    = {{WIDTH{1'b0}}, B};
            rem_d    = '0;
            cnt_d    = CNT_INIT;
            is_div_d = 1'b0;
            busy_d   = 1'b1;
            state_d  = S_EXEC;
          end else if ((ALUOperation == OP_DIVU) && (B != '0)) begin
            opnd_d   = B;
            acc_d    = {{WIDTH{1'b0}}, A};
            rem_d    = '0;
            cnt_d    = CNT_INIT;
            is_div_d = 1'b1;
            busy_d   = 1'b1;
            state_d  = S_EXEC;
          end else if (ALUOperation == OP_DIVU) begin
            res_d   = '1;
            hi_d    = A;
            zero_d  = 1'b0;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            res_d   = single_res;
            hi_d    = '0;
            zero_d  = (single_res == '0);
            done_d  = 1'b1;
            state_d = S_FIN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q - CNT_LAST;
        if (is_div_q) begin
          acc_d = {acc_q[2*WIDTH-1:WIDTH], div_q_next};
          rem_d = div_rem_next;
        end else begin
          acc_d = mul_next;
          rem_d = rem_q;
        end
        // The final iteration writes its result straight into the output registers.
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          if (is_div_q) begin
            res_d  = div_q_next;
            hi_d   = div_rem_next;
            zero_d = (div_q_next == '0);
          end else begin
            res_d  = mul_next[WIDTH-1:0];
            hi_d   = mul_next[2*WIDTH-1:WIDTH];
            zero_d = (mul_next[WIDTH-1:0] == '0);
          end
        end else begin
          state_d = S_EXEC;
          busy_d  = 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      res_q    <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b1;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      res_q    <= res_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign ALUResult = res_q;
  assign ResultHi  = hi_q;
  assign Zero      = zero_q;
  assign DivByZero = dbz_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the datapath ALU.
- Keeps the five logic/arithmetic ops with the same opcodes, registered with one-cycle latency.
- Adds shifts and two iterative ops: unsigned multiply (shift-add) and unsigned divide (restoring).
- Uses a Start/Busy/Done handshake so the multi-cycle control unit can stall on long ops.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 4.
- SHW, $clog2(WIDTH), shift-amount field width taken from A[SHW-1:0].

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Start  input  1  launch an op; sampled only in IDLE.
- ALUOperation  input  4  opcode, captured on accepted Start.
- A  input  WIDTH  operand A (shift amount for shifts), captured on accepted Start.
- B  input  WIDTH  operand B, captured on accepted Start.
- Busy  output  1  high while an op is in flight.
- Done  output  1  one-cycle pulse; results valid from this cycle.
- ALUResult  output  WIDTH  result, low product word, or quotient.
- ResultHi  output  WIDTH  high product word or remainder; 0 for other ops.
- Zero  output  1  (ALUResult == 0), registered with ALUResult.
- DivByZero  output  1  set with Done when DIVU has B == 0, else 0.

Behaviour:
- Opcodes:
  - AND 0000: A&B.
  - OR 0001: A|B.
  - NOR 0010: ~(A|B).
  - ADD 0011: A+B mod 2^WIDTH, carry dropped.
  - SUB 0100: A-B mod 2^WIDTH.
  - SLL 0101: B << A[SHW-1:0].
  - SRL 0110: B >> A[SHW-1:0], logical.
  - MULU 0111: {ResultHi,ALUResult} = A*B, unsigned 2*WIDTH product.
  - DIVU 1000: ALUResult = A/B, ResultHi = A%B, unsigned.
  - 1001–1111: ALUResult = 0, ResultHi = 0, Zero = 1, single-cycle.
- Reset (async, reset==0): state IDLE; Busy 0, Done 0, ALUResult 0, ResultHi 0, Zero 1, DivByZero 0; internal accumulators and counter cleared. A reset mid-operation aborts it with no Done.
- FSM states IDLE, EXEC, FIN:
  - IDLE with Start=1 and a single-cycle op (including illegal opcodes): compute from the live inputs and register the result. FIN on the next edge (Done=1, Busy=0). Latency 1 cycle.
  - IDLE with Start=1 and MULU/DIVU: latch operands, clear the accumulator, load counter = WIDTH, go to EXEC. Busy=1 from the next cycle.
  - IDLE with Start=0: stay.
  - EXEC: one iteration per cycle, counter decrements. When counter reaches 1, results are written and the FSM goes to FIN. MULU/DIVU latency is WIDTH+1 cycles from Start to Done.
  - DIVU with B==0 skips EXEC: ALUResult = all-ones, ResultHi = A, DivByZero = 1, latency 1.
  - FIN: Done=1 for exactly one cycle, then IDLE. A Start asserted during FIN is ignored; the earliest next accepted Start is the cycle after FIN. Back-to-back single-cycle ops therefore issue every 2 cycles.
- Start while Busy (EXEC) is ignored and has no effect on the in-flight op. Input changes during EXEC are ignored because operands are latched.
- ALUResult, ResultHi, Zero and DivByZero hold their values from Done until the next Done. They are updated only in the cycle that enters FIN.
- DivByZero is cleared at the next accepted Start.
- Multiply: a 2*WIDTH accumulator; each cycle add the multiplicand when the multiplier LSB is 1, then shift right. The result is exact for all unsigned inputs.
- Divide: restoring algorithm with a WIDTH+1-bit partial remainder; remainder is always < B.

Test Plan:
- Reset mid-op: MULU 7*9 started, reset pulled low at cycle 10 → all outputs at reset values, no Done; after release Busy=0 and the FSM is in IDLE.
- Single-cycle ops, WIDTH=32:
  - ADD A=0xFFFFFFFF, B=1 → Done 1 cycle after Start; ALUResult=0, Zero=1.
  - SUB 5-7 → 0xFFFFFFFE, Zero=0.
  - NOR 0,0 → 0xFFFFFFFF.
  - Illegal opcode 1111 → ALUResult=0, Zero=1.
- Shifts: SLL A=4, B=0x0000000F → 0x000000F0. SRL A=31, B=0x80000000 → 1. SRL A=0 → ALUResult=B.
- MULU A=0xFFFFFFFF, B=0xFFFFFFFF:
  - Busy high 32 cycles, Done at cycle 33.
  - ResultHi=0xFFFFFFFE, ALUResult=0x00000001.
  - A Start pulsed during EXEC with ADD is ignored (no extra Done).
- DIVU:
  - A=100, B=7 → ALUResult=14, ResultHi=2, latency 33, DivByZero=0.
  - A=5, B=0 → Done after 1 cycle; ALUResult=0xFFFFFFFF, ResultHi=5, DivByZero=1.
- Hold and reissue: after Done, inputs changed without Start → outputs unchanged. Start held high continuously → ops accepted every 2 cycles (single-cycle ops).
